aes256_inv_cipher_ctrl: RTL and testbench

Iterative AES-256 decryption controller. It accepts one 128-bit ciphertext block over a valid/ready handshake and holds it in a state register. It steps the block through the initial AddRoundKey, 13 full inverse rounds and the final inverse round, one round per clock, fetching round keys by index from the key-schedule store. It sits between the decryption front end and the round-key RAM and owns the only state register of the inverse-cipher datapath.

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes256_inv_cipher_ctrl_if.sv | 27 ++
 rtl/aes_inv_round.sv | 36 +++
 rtl/aes256_inv_cipher_ctrl.sv | 112 +++++++++++
 tb/tb_aes256_inv_cipher_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES-256 inverse-cipher datapath.
// Byte 0 of a state word sits at [127:120]; bytes fill the state column by column.
package aes_pkg;

    localparam int NR_AES256 = 14;

    typedef logic [127:0] state_t;
    typedef logic [3:0]   rk_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes256_inv_cipher_ctrl_if.sv
// Block handshake, plaintext output and round-key fetch bundle of the inverse-cipher controller.
interface aes256_inv_cipher_ctrl_if;
    import aes_pkg::*;

    logic    in_valid;
    logic    in_ready;
    state_t  in_data;
    logic    key_ready;
    rk_idx_t rk_idx;
    state_t  rk_in;
    logic    key_lock;
    logic    out_valid;
    logic    out_ready;
    state_t  out_data;
    logic    busy;

    modport slave (
        input  in_valid, in_data, key_ready, rk_in, out_ready,
        output in_ready, rk_idx, key_lock, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, key_ready, rk_in, out_ready,
        input  in_ready, rk_idx, key_lock, out_valid, out_data, busy
    );

endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t st_i,
    input  state_t rk_i,
    input  logic   final_i,
    output state_t st_o
);

    state_t sr_s;
    state_t sb_s;
    state_t ark_s;
    state_t mc_s;

    // Round datapath; the final round skips the column mix.
    always_comb begin
        sr_s = inv_shift_rows(st_i);
        sb_s = '0;
        mc_s = '0;
        for (int b = 0; b < 16; b++) begin
            sb_s[127-8*b -: 8] = inv_sbox(sr_s[127-8*b -: 8]);
        end
        ark_s = sb_s ^ rk_i;
        for (int c = 0; c < 4; c++) begin
            mc_s[127-32*c -: 32] = inv_mix_col(ark_s[127-32*c -: 32]);
        end
        if (final_i) begin
            st_o = ark_s;
        end else begin
            st_o = mc_s;
        end
    end

endmodule

// File: rtl/aes256_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher controller: one round per clock, round keys fetched by index.
// Holds the only state register of the datapath; blocks never overlap.
module aes256_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES256
)
(
    input  logic                     clk,
    input  logic                     rst,
    aes256_inv_cipher_ctrl_if.slave  bus
);

    localparam rk_idx_t NR_IDX    = rk_idx_t'(NR);
    localparam rk_idx_t NR_M1_IDX = rk_idx_t'(NR - 1);

    ctrl_state_t state_q, state_d;
    state_t      st_q, st_d;
    rk_idx_t     rnd_q, rnd_d;
    rk_idx_t     rk_idx_q, rk_idx_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    state_t      round_st_s;
    logic        final_s;

    assign final_s = (rnd_q == 4'd0);

    aes_inv_round u_round (
        .st_i    (st_q),
        .rk_i    (bus.rk_in),
        .final_i (final_s),
        .st_o    (round_st_s)
    );

    // Next-state logic; rk_idx is kept equal to rnd during rounds and NR otherwise.
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rnd_d       = rnd_q;
        rk_idx_d    = rk_idx_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.key_ready) begin
                    st_d     = bus.in_data ^ bus.rk_in;
                    rnd_d    = NR_M1_IDX;
                    rk_idx_d = NR_M1_IDX;
                    busy_d   = 1'b1;
                    state_d  = ROUND;
                end else begin
                    state_d  = IDLE;
                end
            end
            ROUND: begin
                st_d = round_st_s;
                if (rnd_q != 4'd0) begin
                    rnd_d    = rnd_q - 4'd1;
                    rk_idx_d = rnd_q - 4'd1;
                end else begin
                    rk_idx_d    = NR_IDX;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = DONE;
                end
            end
            default: begin
                st_d        = '0;
                rnd_d       = 4'd0;
                rk_idx_d    = NR_IDX;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // All controller state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rnd_q       <= 4'd0;
            rk_idx_q    <= NR_IDX;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rnd_q       <= rnd_d;
            rk_idx_q    <= rk_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && bus.key_ready;
    assign bus.rk_idx    = rk_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = st_q;
    assign bus.busy      = busy_q;
    assign bus.key_lock  = busy_q;

endmodule

// File: tb/tb_aes256_inv_cipher_ctrl.sv
// Scoreboard bench for aes256_inv_cipher_ctrl: plaintexts come from FIPS-197 constants or
// from an independent forward-cipher model; round keys are expanded here.
module tb_aes256_inv_cipher_ctrl;
    import aes_pkg::*;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst;

    aes256_inv_cipher_ctrl_if bus();

    aes256_inv_cipher_ctrl #(.NR(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [127:0] rk_tab [16];
    logic [7:0]   sbox [256];
    logic [127:0] exp_q [$];
    int           n_checks = 0;
    int           n_fails  = 0;
    int           cyc      = 0;
    int           acc_cnt  = 0;
    int           acc_cyc  = 0;
    logic         ov_prev  = 1'b0;

    assign bus.rk_in = rk_tab[bus.rk_idx];

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box by brute-force inverse search plus the forward affine map.
    task automatic build_sbox();
        logic [7:0] a;
        for (int x = 0; x < 256; x++) begin
            a = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (mul(8'(x), 8'(y)) == 8'h01) a = 8'(y);
            end
            sbox[x] = a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk_tab[15] = '0;
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= 14; r++) begin
            for (int b = 0; b < 16; b++) t[127-8*b -: 8] = sbox[s[127-8*b -: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[127-8*(4*c+w) -: 8] = t[127-8*(4*((c+w)%4)+w) -: 8];
            if (r != 14) begin
                for (int c = 0; c < 4; c++) begin
                    {a0, a1, a2, a3} = s[127-32*c -: 32];
                    t[127-32*c -: 32] = {mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3,
                                         a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3,
                                         a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03),
                                         mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02)};
                end
                s = t;
            end
            s = s ^ rk_tab[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Presents a block, pushes its expected plaintext on accept and returns in cycle T0+1.
    task automatic send(input logic [127:0] ct, input logic [127:0] pt);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = ct;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                exp_q.push_back(pt);
                check_eq("rk_idx_accept", bus.rk_idx, 14);
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("send_accepted", ok, 1'b1);
    endtask

    task automatic wait_ov(input int budget);
        for (int i = 0; i < budget && !bus.out_valid; i++) begin
            @(posedge clk); #1;
        end
        check_eq("out_valid_seen", bus.out_valid, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check_eq("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Monitor: counts accepts, checks latency and compares plaintext against the scoreboard.
    always @(negedge clk) begin
        logic [127:0] e;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (bus.out_valid && !ov_prev) check_eq("latency", cyc - acc_cyc, 15);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else e = {128{1'bx}};
                check_eq("out_data", bus.out_data, e);
            end
            ov_prev = bus.out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] pt, ct, pt2, ct2;
        int t_a, h_cyc, c0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.key_ready = 1'b1;
        bus.out_ready = 1'b1;
        build_sbox();
        expand_key(C3_KEY);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_key_lock", bus.key_lock, 1'b0);
        check_eq("rst_rk_idx", bus.rk_idx, 14);
        check_eq("rst_out_data", bus.out_data, 128'h0);
        check_eq("rst_in_ready_hi", bus.in_ready, 1'b1);
        bus.key_ready = 1'b0;
        #1;
        check_eq("rst_in_ready_lo", bus.in_ready, 1'b0);
        bus.key_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // FIPS-197 C.3 vector with the round-key index walk.
        send(C3_CT, C3_PT);
        for (int k = 13; k >= 0; k--) begin
            check_eq("rk_idx_round", bus.rk_idx, k);
            check_eq("in_ready_round", bus.in_ready, 1'b0);
            check_eq("key_lock_round", bus.key_lock, 1'b1);
            @(posedge clk); #1;
        end
        check_eq("done_out_valid", bus.out_valid, 1'b1);
        check_eq("done_out_data", bus.out_data, C3_PT);
        @(posedge clk); #1;
        check_eq("rk_idx_idle", bus.rk_idx, 14);
        check_eq("busy_idle", bus.busy, 1'b0);
        wait_drain();

        // Backpressure: output held for 20 cycles with a second block waiting.
        pt  = rand128(); ct  = encrypt(pt);
        pt2 = rand128(); ct2 = encrypt(pt2);
        bus.out_ready = 1'b0;
        send(ct, pt);
        wait_ov(40);
        bus.in_valid = 1'b1;
        bus.in_data  = ct2;
        c0 = acc_cnt;
        repeat (20) begin
            check_eq("bp_out_data", bus.out_data, pt);
            check_eq("bp_out_valid", bus.out_valid, 1'b1);
            check_eq("bp_in_ready", bus.in_ready, 1'b0);
            @(posedge clk); #1;
        end
        check_eq("bp_no_accept", acc_cnt - c0, 0);
        bus.out_ready = 1'b1;
        h_cyc = cyc;
        send(ct2, pt2);
        check_eq("bp_idle_next", acc_cyc - h_cyc, 1);
        wait_drain();

        // Back-to-back throughput with out_ready high.
        pt  = rand128(); ct  = encrypt(pt);
        pt2 = rand128(); ct2 = encrypt(pt2);
        send(ct, pt);
        t_a = acc_cyc;
        send(ct2, pt2);
        check_eq("throughput", acc_cyc - t_a, 16);
        wait_drain();

        // Key gating, then key_ready dropped at round 5 of an in-flight block.
        bus.key_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = C3_CT;
        c0 = acc_cnt;
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("gate_in_ready", bus.in_ready, 1'b0);
        end
        check_eq("gate_no_accept", acc_cnt - c0, 0);
        bus.key_ready = 1'b1;
        pt = rand128(); ct = encrypt(pt);
        send(ct, pt);
        repeat (4) @(posedge clk);
        #1;
        bus.key_ready = 1'b0;
        bus.out_ready = 1'b0;
        wait_ov(30);
        repeat (3) begin
            check_eq("lock_held", bus.key_lock, 1'b1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        check_eq("lock_at_handshake", bus.key_lock, 1'b1);
        @(posedge clk); #1;
        check_eq("lock_released", bus.key_lock, 1'b0);
        bus.key_ready = 1'b1;
        wait_drain();

        // Reset at round 7 discards the block; the vector then decrypts normally.
        send(C3_CT, C3_PT);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", bus.out_valid, 1'b0);
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        check_eq("mid_rst_rk_idx", bus.rk_idx, 14);
        check_eq("mid_rst_key_lock", bus.key_lock, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(C3_CT, C3_PT);
        wait_drain();

        // Random in_valid traffic during ROUND and DONE must not be consumed.
        c0 = acc_cnt;
        bus.out_ready = 1'b0;
        send(C3_CT, C3_PT);
        repeat (17) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = rand128();
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        check_eq("single_accept", acc_cnt - c0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
